// File: rtl/axis_pcie_tlp_log_pkg.sv
// Record format and TLP header field offsets for the PCIe TLP log capture path.
// Optional macro AXIS_PCIE_TLP_LOG_PAYLOAD_EN adds payload_dw0 to the record.
package axis_pcie_tlp_log_pkg;

  localparam int TLP_LOG_BEATS_W = 12;
  localparam int TLP_LOG_TS_W    = 64;

  // Bit offsets of header fields within the SOP beat of tap_tdata
  localparam int HDR_LEN_LSB      = 0;
  localparam int HDR_LEN_W        = 10;
  localparam int HDR_FMT_TYPE_LSB = 24;
  localparam int HDR_TAG_LSB      = 40;
  localparam int HDR_REQ_ID_LSB   = 48;
  localparam int HDR_DW2_LSB      = 64;
  localparam int HDR_DW3_LSB      = 96;
  localparam int HDR_PLD_3DW_LSB  = 96;
  localparam int HDR_PLD_4DW_LSB  = 128;

  typedef enum logic {
    TLP_LOG_KIND_TLP  = 1'b0,
    TLP_LOG_KIND_DROP = 1'b1
  } tlp_log_kind_e;

  typedef struct packed {
    tlp_log_kind_e               kind;
    logic [TLP_LOG_TS_W-1:0]     ts;
    logic [7:0]                  fmt_type;
    logic [HDR_LEN_W-1:0]        len_dw;
    logic [15:0]                 req_id;
    logic [7:0]                  tag;
    logic [63:0]                 addr;
    logic [TLP_LOG_BEATS_W-1:0]  beats;
`ifdef AXIS_PCIE_TLP_LOG_PAYLOAD_EN
    logic [31:0]                 payload_dw0;
`endif
  } tlp_log_rec_t;

  // fmt[0] (fmt_type[5]) selects the 4DW header with a 64-bit address
  function automatic logic [63:0] tlp_addr(input logic [7:0] fmt_type,
                                           input logic [31:0] dw2,
                                           input logic [31:0] dw3);
    return fmt_type[5] ? {dw2, dw3} : {32'h0, dw2[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/axis_pcie_tlp_log_fifo.sv
// Show-ahead FIFO for log records; dout reads as zero while empty.
module axis_pcie_tlp_log_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     din,
  output logic full,
  input  logic pop,
  output T     dout,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO only lands when a pop frees the slot this cycle
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/axis_pcie_tlp_log_capture.sv
// Passive AXI-S PCIe TLP tap: decodes headers, timestamps and queues log records.
// Optional macro AXIS_PCIE_TLP_LOG_PAYLOAD_EN captures the first payload DW.
module axis_pcie_tlp_log_capture
  import axis_pcie_tlp_log_pkg::*;
#(
  parameter int TDATA_W    = 256,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 64
) (
  input  logic                              clk,
  input  logic                              SoftReset_n,
  input  logic                              capture_en,
  input  logic                              tap_tvalid,
  input  logic                              tap_tready,
  input  logic                              tap_tlast,
  input  logic [TDATA_W-1:0]                tap_tdata,
  output logic                              rec_valid,
  input  logic                              rec_ready,
  output logic [$bits(tlp_log_rec_t)-1:0]   rec_data,
  output logic [15:0]                       drop_cnt,
  output logic                              in_pkt
);

  typedef enum logic {ST_IDLE, ST_IN_PKT} state_e;

  state_e                      state_reg, state_next;
  logic                        skip_reg, skip_next;
  tlp_log_rec_t                cur_reg, cur_next;
  tlp_log_rec_t                sop_rec, tlp_rec, drop_rec, fifo_din, fifo_dout;
  logic [TS_W-1:0]             ts_reg;
  logic [TLP_LOG_TS_W-1:0]     ts_now;
  logic [TLP_LOG_BEATS_W-1:0]  beats_inc;
  logic [TLP_LOG_BEATS_W-1:0]  pend_drops_reg;
  logic                        drop_pend_reg;
  logic [15:0]                 drop_cnt_reg;
  logic [159:0]                hdr;
  logic                        beat, tlp_push, sum_push, tlp_drop, fifo_push, pop;
  logic                        fifo_full, fifo_empty;

  assign beat   = tap_tvalid & tap_tready;
  assign ts_now = TLP_LOG_TS_W'(ts_reg);

  // Narrow taps are zero-extended so the 4DW payload slice is always in range
  generate
    if (TDATA_W >= 160) begin : g_hdr_full
      assign hdr = tap_tdata[159:0];
    end else begin : g_hdr_pad
      assign hdr = {{(160-TDATA_W){1'b0}}, tap_tdata};
    end
  endgenerate

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) ts_reg <= '0;
    else              ts_reg <= ts_reg + TS_W'(1);
  end

  always_comb begin
    sop_rec          = '0;
    sop_rec.kind     = TLP_LOG_KIND_TLP;
    sop_rec.ts       = ts_now;
    sop_rec.fmt_type = hdr[HDR_FMT_TYPE_LSB +: 8];
    sop_rec.len_dw   = hdr[HDR_LEN_LSB +: HDR_LEN_W];
    sop_rec.req_id   = hdr[HDR_REQ_ID_LSB +: 16];
    sop_rec.tag      = hdr[HDR_TAG_LSB +: 8];
    sop_rec.addr     = tlp_addr(hdr[HDR_FMT_TYPE_LSB +: 8],
                                hdr[HDR_DW2_LSB +: 32], hdr[HDR_DW3_LSB +: 32]);
    sop_rec.beats    = TLP_LOG_BEATS_W'(1);
`ifdef AXIS_PCIE_TLP_LOG_PAYLOAD_EN
    if (hdr[HDR_FMT_TYPE_LSB + 6])
      sop_rec.payload_dw0 = hdr[HDR_FMT_TYPE_LSB + 5] ? hdr[HDR_PLD_4DW_LSB +: 32]
                                                      : hdr[HDR_PLD_3DW_LSB +: 32];
`endif
  end

  assign beats_inc = (cur_reg.beats == '1) ? cur_reg.beats
                                           : cur_reg.beats + TLP_LOG_BEATS_W'(1);

  always_comb begin
    state_next = state_reg;
    skip_next  = skip_reg;
    cur_next   = cur_reg;
    tlp_push   = 1'b0;
    tlp_rec    = cur_reg;
    case (state_reg)
      ST_IDLE: begin
        if (beat) begin
          if (capture_en) begin
            if (tap_tlast) begin
              tlp_push = 1'b1;
              tlp_rec  = sop_rec;
            end else begin
              state_next = ST_IN_PKT;
              skip_next  = 1'b0;
              cur_next   = sop_rec;
            end
          end else if (!tap_tlast) begin
            // A skipped single-beat packet is already over; stay idle
            state_next = ST_IN_PKT;
            skip_next  = 1'b1;
          end
        end
      end
      ST_IN_PKT: begin
        if (beat) begin
          cur_next.beats = beats_inc;
          tlp_rec.beats  = beats_inc;
          if (tap_tlast) begin
            state_next = ST_IDLE;
            tlp_push   = ~skip_reg;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state_reg <= ST_IDLE;
      skip_reg  <= 1'b0;
      cur_reg   <= '0;
    end else begin
      state_reg <= state_next;
      skip_reg  <= skip_next;
      cur_reg   <= cur_next;
    end
  end

  assign pop      = rec_valid & rec_ready;
  assign tlp_drop = tlp_push & fifo_full & ~pop;
  // Summary waits for a free slot and yields to any TLP record
  assign sum_push = drop_pend_reg & ~fifo_full & ~tlp_push;

  always_comb begin
    drop_rec       = '0;
    drop_rec.kind  = TLP_LOG_KIND_DROP;
    drop_rec.ts    = ts_now;
    drop_rec.beats = pend_drops_reg;
  end

  assign fifo_push = tlp_push | sum_push;
  assign fifo_din  = tlp_push ? tlp_rec : drop_rec;

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      drop_cnt_reg   <= '0;
      pend_drops_reg <= '0;
      drop_pend_reg  <= 1'b0;
    end else if (tlp_drop) begin
      if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      if (pend_drops_reg != '1)     pend_drops_reg <= pend_drops_reg + TLP_LOG_BEATS_W'(1);
      drop_pend_reg <= 1'b1;
    end else if (sum_push) begin
      pend_drops_reg <= '0;
      drop_pend_reg  <= 1'b0;
    end
  end

  axis_pcie_tlp_log_fifo #(
    .T     (tlp_log_rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (SoftReset_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign rec_valid = ~fifo_empty;
  assign rec_data  = fifo_dout;
  assign drop_cnt  = drop_cnt_reg;
  assign in_pkt    = (state_reg == ST_IN_PKT);

endmodule

// File: tb/tb_axis_pcie_tlp_log_capture.sv
// Scoreboard bench for axis_pcie_tlp_log_capture: expected records are queued as
// packets are driven and compared as the record stream is drained.
module tb_axis_pcie_tlp_log_capture;
  import axis_pcie_tlp_log_pkg::*;

  localparam int TDATA_W    = 256;
  localparam int FIFO_DEPTH = 16;
  localparam int TS_W       = 64;

  logic                              clk = 1'b0;
  logic                              SoftReset_n = 1'b0;
  logic                              capture_en = 1'b0;
  logic                              tap_tvalid = 1'b0;
  logic                              tap_tready = 1'b0;
  logic                              tap_tlast = 1'b0;
  logic [TDATA_W-1:0]                tap_tdata = '0;
  logic                              rec_valid;
  logic                              rec_ready = 1'b0;
  logic [$bits(tlp_log_rec_t)-1:0]   rec_data;
  logic [15:0]                       drop_cnt;
  logic                              in_pkt;

  int            n_checks = 0;
  int            n_fail = 0;
  tlp_log_rec_t  exp_q[$];
  tlp_log_rec_t  mon_got, mon_exp;
  logic [63:0]   tb_ts;

  axis_pcie_tlp_log_capture #(
    .TDATA_W    (TDATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TS_W       (TS_W)
  ) dut (
    .clk         (clk),
    .SoftReset_n (SoftReset_n),
    .capture_en  (capture_en),
    .tap_tvalid  (tap_tvalid),
    .tap_tready  (tap_tready),
    .tap_tlast   (tap_tlast),
    .tap_tdata   (tap_tdata),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_data    (rec_data),
    .drop_cnt    (drop_cnt),
    .in_pkt      (in_pkt)
  );

  always #5 clk = ~clk;

  // Reference timestamp: cycles since reset release
  always @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) tb_ts <= 64'd0;
    else              tb_ts <= tb_ts + 64'd1;
  end

  // Record consumer: a pop happens on the next rising edge
  always @(negedge clk) begin
    if (SoftReset_n && rec_valid && rec_ready) begin
      mon_got = rec_data;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_record: got %h, required no record", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          n_fail++;
          $display("FAIL record: got %h, required %h", mon_got, mon_exp);
        end
      end
      $display("rec kind=%0d ts=%0d fmt_type=%h len=%0d req_id=%h tag=%h addr=%h beats=%0d",
               mon_got.kind, mon_got.ts, mon_got.fmt_type, mon_got.len_dw,
               mon_got.req_id, mon_got.tag, mon_got.addr, mon_got.beats);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  function automatic logic [TDATA_W-1:0] mk(input logic [31:0] dw0, input logic [31:0] dw1,
                                            input logic [31:0] dw2, input logic [31:0] dw3,
                                            input logic [31:0] dw4);
    return {96'h0, dw4, dw3, dw2, dw1, dw0};
  endfunction

  function automatic tlp_log_rec_t make_tlp(input logic [63:0] ts, input logic [TDATA_W-1:0] d,
                                            input int beats);
    tlp_log_rec_t r;
    r          = '0;
    r.kind     = TLP_LOG_KIND_TLP;
    r.ts       = ts;
    r.fmt_type = d[31:24];
    r.len_dw   = d[9:0];
    r.req_id   = d[63:48];
    r.tag      = d[47:40];
    r.addr     = d[29] ? {d[95:64], d[127:96]} : {32'h0, d[95:66], 2'b00};
    r.beats    = beats[11:0];
`ifdef AXIS_PCIE_TLP_LOG_PAYLOAD_EN
    r.payload_dw0 = d[30] ? (d[29] ? d[159:128] : d[127:96]) : 32'h0;
`endif
    return r;
  endfunction

  function automatic tlp_log_rec_t make_drop(input logic [63:0] ts, input int n);
    tlp_log_rec_t r;
    r       = '0;
    r.kind  = TLP_LOG_KIND_DROP;
    r.ts    = ts;
    r.beats = n[11:0];
    return r;
  endfunction

  task automatic drive_beat(input logic [TDATA_W-1:0] d, input logic last, input logic en);
    tap_tdata  = d;
    tap_tlast  = last;
    capture_en = en;
    tap_tvalid = 1'b1;
    tap_tready = 1'b1;
    @(posedge clk); #1;
    tap_tvalid = 1'b0;
    tap_tlast  = 1'b0;
  endtask

  task automatic send_single(input logic [TDATA_W-1:0] d, input logic expect_rec);
    if (expect_rec) exp_q.push_back(make_tlp(tb_ts, d, 1));
    drive_beat(d, 1'b1, 1'b1);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d records outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
    n_checks++;
    if (rec_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_empty: got rec_valid=%b, required 0", rec_valid);
    end
  endtask

  task automatic test_reset();
    SoftReset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rec_valid: got %b, required 0", rec_valid); end
    n_checks++; if (rec_data !== '0) begin n_fail++; $display("FAIL reset_rec_data: got %h, required 0", rec_data); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
    n_checks++; if (in_pkt !== 1'b0) begin n_fail++; $display("FAIL reset_in_pkt: got %b, required 0", in_pkt); end
    @(negedge clk);
    SoftReset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_rec_valid: got %b, required 0", rec_valid); end
  endtask

  task automatic test_single_mrd();
    logic [TDATA_W-1:0] d;
    d = mk(32'h0000_0001, 32'h0100_0A0F, 32'h8000_1000, 32'h0, 32'h0);
    rec_ready = 1'b0;
    exp_q.push_back(make_tlp(tb_ts, d, 1));
    tap_tdata = d; tap_tlast = 1'b1; capture_en = 1'b1; tap_tvalid = 1'b1; tap_tready = 1'b1;
    #2;
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL mrd_pre_eop_valid: got %b, required 0", rec_valid); end
    @(posedge clk); #1;
    tap_tvalid = 1'b0; tap_tlast = 1'b0;
    n_checks++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL mrd_latency: got rec_valid=%b, required 1", rec_valid); end
    rec_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_mwr_multibeat();
    logic [TDATA_W-1:0] d0;
    d0 = mk(32'h6000_0004, 32'h0200_1B0F, 32'h0000_0012, 32'h3456_7800, 32'hCAFE_0001);
    rec_ready = 1'b1;
    exp_q.push_back(make_tlp(tb_ts, d0, 4));
    drive_beat(d0, 1'b0, 1'b1);
    n_checks++; if (in_pkt !== 1'b1) begin n_fail++; $display("FAIL mwr_in_pkt: got %b, required 1", in_pkt); end
    @(posedge clk); #1;                        // tvalid gap
    tap_tdata = '1; tap_tlast = 1'b1; tap_tvalid = 1'b1; tap_tready = 1'b0;
    @(posedge clk); #1;                        // ready stall with tlast, not a beat
    tap_tvalid = 1'b0; tap_tlast = 1'b0;
    drive_beat(mk(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5), 1'b0, 1'b1);
    drive_beat(mk(32'h6666_6666, 32'h7, 32'h8, 32'h9, 32'hA), 1'b0, 1'b1);
    drive_beat(mk(32'hB, 32'hC, 32'hD, 32'hE, 32'hF), 1'b1, 1'b0);
    wait_drain();
  endtask

  task automatic test_capture_skip();
    rec_ready = 1'b1;
    drive_beat(mk(32'h4000_0002, 32'h0400_2C0F, 32'hA000_0000, 32'h0, 32'h1), 1'b0, 1'b0);
    n_checks++; if (in_pkt !== 1'b1) begin n_fail++; $display("FAIL skip_in_pkt: got %b, required 1", in_pkt); end
    drive_beat(mk(32'h5, 32'h6, 32'h7, 32'h8, 32'h9), 1'b0, 1'b1);
    drive_beat(mk(32'hA, 32'hB, 32'hC, 32'hD, 32'hE), 1'b1, 1'b1);
    n_checks++; if (in_pkt !== 1'b0) begin n_fail++; $display("FAIL skip_end_in_pkt: got %b, required 0", in_pkt); end
    send_single(mk(32'h0000_0003, 32'h0500_3D0F, 32'hB000_0004, 32'h0, 32'h0), 1'b1);
    wait_drain();
  endtask

  task automatic test_overflow();
    rec_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      send_single(mk(32'h0000_0002, {16'h0300, 8'(i), 8'h0F}, 32'h1000_0000 + 32'(i * 4),
                     32'h0, 32'h0), (i < FIFO_DEPTH));
    @(posedge clk); #1;
    n_checks++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL overflow_drop_cnt: got %0d, required 4", drop_cnt); end
    n_checks++; if (rec_valid !== 1'b1) begin n_fail++; $display("FAIL overflow_rec_valid: got %b, required 1", rec_valid); end
    exp_q.push_back(make_drop(tb_ts + 64'd1, 4));
    rec_ready = 1'b1;
    wait_drain();
    n_checks++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL overflow_drop_cnt_hold: got %0d, required 4", drop_cnt); end
  endtask

  task automatic test_full_push_pop();
    rec_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      send_single(mk(32'h0000_0001, {16'h0600, 8'(i), 8'h0F}, 32'h2000_0000 + 32'(i * 8),
                     32'h0, 32'h0), 1'b1);
    rec_ready = 1'b1;
    send_single(mk(32'h0000_0001, 32'h0700_770F, 32'h3000_0000, 32'h0, 32'h0), 1'b1);
    rec_ready = 1'b0;
    n_checks++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL pushpop_drop_cnt: got %0d, required 4", drop_cnt); end
    @(posedge clk); #1;
    rec_ready = 1'b1;
    wait_drain();
    n_checks++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL pushpop_drop_cnt_end: got %0d, required 4", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [TDATA_W-1:0] dcont;
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send_single(mk(32'h0000_0001, {16'h0800, 8'(i), 8'h0F}, 32'h4000_0000, 32'h0, 32'h0), 1'b1);
    drive_beat(mk(32'h6000_0008, 32'h0900_990F, 32'h0, 32'h5000_0000, 32'h1), 1'b0, 1'b1);
    n_checks++; if (in_pkt !== 1'b1) begin n_fail++; $display("FAIL pre_rst_in_pkt: got %b, required 1", in_pkt); end
    #2;
    SoftReset_n = 1'b0;
    #1;
    n_checks++; if (rec_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rec_valid: got %b, required 0", rec_valid); end
    n_checks++; if (rec_data !== '0) begin n_fail++; $display("FAIL rst_mid_rec_data: got %h, required 0", rec_data); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_mid_drop_cnt: got %0d, required 0", drop_cnt); end
    n_checks++; if (in_pkt !== 1'b0) begin n_fail++; $display("FAIL rst_mid_in_pkt: got %b, required 0", in_pkt); end
    exp_q.delete();
    @(negedge clk);
    SoftReset_n = 1'b1;
    @(posedge clk); #1;
    // Continuation of the interrupted packet becomes a fresh single-beat SOP
    dcont = mk(32'h4000_0001, 32'h0A00_AA0F, 32'h6000_0010, 32'hDEAD_BEEF, 32'h0);
    send_single(dcont, 1'b1);
    send_single(mk(32'h0000_0001, 32'h0B00_BB0F, 32'h7000_0020, 32'h0, 32'h0), 1'b1);
    rec_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_single_mrd();
    test_mwr_multibeat();
    test_capture_skip();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
